writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk (rising edge), rst_n (async assert, sync release).
REQ-002 SHALL have parameter DEPTH, default 4, meaning result-queue entries (power of two, >=2).
REQ-003 SHALL have ports:
  clk           in   1   clock
  rst_n         in   1   async reset, active low
  res_valid     in   1   producer offers a result
  res_ready     out  1   queue can accept
  res_data      in   32  result value (integer or float bits)
  res_dest      in   5   destination register index
  res_is_float  in   1   1 = FP register file, 0 = GPR file
  wb_stall      in   1   hold queue head, no write this cycle
  flush         in   1   discard all queued results
  reg_write     out  1   GPR write enable
  float_write   out  1   FP write enable
  rd            out  5   GPR write index
  frd           out  5   FP write index
  write_data    out  32  write value for either file
  busy_gpr      out  32  pending-GPR-destination mask
  busy_fpr      out  32  pending-FP-destination mask
  count         out  log2(DEPTH)+1  queued entries

Function
REQ-004 SHALL store accepted results in a FIFO of DEPTH entries {data, dest, is_float}, read and write pointers wrapping modulo DEPTH.
REQ-005 SHALL drive res_ready = (count != DEPTH) && !flush, combinationally.
REQ-006 SHALL enqueue on a rising edge where res_valid && res_ready; res_valid while res_ready low SHALL be ignored, not lost silently by the queue (producer holds).
REQ-007 SHALL provide no bypass: a result enqueued at edge N is first presented on the write ports in the cycle after edge N; minimum latency enqueue-to-register-commit is 2 edges.
REQ-008 SHALL present the head entry combinationally: write_data = head data; rd = frd = head dest.
REQ-009 SHALL assert float_write = (count!=0) && head is_float && !wb_stall && !flush.
REQ-010 SHALL assert reg_write = (count!=0) && !head is_float && head dest!=0 && !wb_stall && !flush.
REQ-011 SHALL dequeue the head on any edge where count!=0 && !wb_stall && !flush, including GPR dest-0 entries (dropped, no write).
REQ-012 SHALL never assert reg_write and float_write together.
REQ-013 SHALL allow simultaneous enqueue and dequeue in one edge; count unchanged, both pointers advance.
REQ-014 SHALL, when empty with wb_stall low, keep both write enables 0 and not move the read pointer.
REQ-015 SHALL hold the head entry and all outputs stable while wb_stall is high; enqueue continues while not full.
REQ-016 SHALL compute busy_gpr[i] = 1 iff any queued entry has is_float=0 and dest=i; busy_gpr[0] SHALL always be 0.
REQ-017 SHALL compute busy_fpr[i] = 1 iff any queued entry has is_float=1 and dest=i.
REQ-018 SHALL, on an edge with flush high, set count to 0 and both pointers to 0, ignoring res_valid and wb_stall that cycle; flush has highest priority after reset.
REQ-019 SHALL keep count in range 0..DEPTH at all times; no overflow or underflow state is reachable.

Reset
REQ-020 SHALL, while rst_n low, force count=0, pointers=0, reg_write=0, float_write=0, busy_gpr=0, busy_fpr=0, independent of clk.
REQ-021 SHALL present res_ready=1 in the first cycle after rst_n deasserts; rst_n asserted mid-stream SHALL discard all queued entries, with no partial write issued.
REQ-022 SHALL leave FIFO data storage unreset; rd, frd, write_data are don't-care while both enables are 0.

Verification
REQ-023 Single int: res_valid, dest=5, data=0x0000_0007, is_float=0 -> next cycle reg_write=1, rd=5, write_data=7, busy_gpr=0x20; following cycle busy_gpr=0, count=0.
REQ-024 Fill: 5 back-to-back results, wb_stall=1 -> after 4 accepts count=4, res_ready=0, 5th held; drop wb_stall -> 5 writes in order, FP entry dest=3 data=0x3F80_0000 gives float_write=1, frd=3.
REQ-025 Dest zero: int result dest=0 -> reg_write stays 0, entry dequeued one cycle later, busy_gpr[0]=0 throughout.
REQ-026 Simultaneous: count=2, res_valid and drain in same edge -> count stays 2, order preserved over pointer wrap (DEPTH+2 total results).
REQ-027 Flush: count=3 plus res_valid in flush cycle -> next cycle count=0, masks 0, no write enable asserted in flush cycle or after.
REQ-028 Async reset: rst_n low mid-cycle with count=4 -> enables and masks 0 immediately, before next clk edge; res_ready=1 after release.

Source files
------------

// File: rtl/writeback_if.sv
// Result-queue bundle between an execution producer and the register-file writeback port.
// Latency: pure wiring, no storage.
// Backpressure: res_ready from the unit gates the producer; wb_stall from the register files holds the head.
interface writeback_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic [4:0]    res_dest;
    logic          res_is_float;
    logic          wb_stall;
    logic          flush;
    logic          reg_write;
    logic          float_write;
    logic [4:0]    rd;
    logic [4:0]    frd;
    logic [31:0]   write_data;
    logic [31:0]   busy_gpr;
    logic [31:0]   busy_fpr;
    logic [CW-1:0] count;

    // The writeback unit side.
    modport slave (
        input  res_valid, res_data, res_dest, res_is_float, wb_stall, flush,
        output res_ready, reg_write, float_write, rd, frd, write_data,
               busy_gpr, busy_fpr, count
    );

    // The producer / register-file side.
    modport master (
        output res_valid, res_data, res_dest, res_is_float, wb_stall, flush,
        input  res_ready, reg_write, float_write, rd, frd, write_data,
               busy_gpr, busy_fpr, count
    );
endinterface

// File: rtl/writeback_unit.sv
// Queues execution results and commits them in order to the GPR or FP register file.
// Latency: 1 cycle enqueue-to-present (no bypass), commit on the following edge.
// Backpressure: res_ready drops when full or flushing; wb_stall freezes the head entry.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    writeback_if.slave wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]      data_q [DEPTH];
    logic [4:0]       dest_q [DEPTH];
    logic [DEPTH-1:0] flt_q;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic          not_empty;
    logic          full;
    logic          rdy;
    logic          push;
    logic          pop;
    logic          head_flt;
    logic [4:0]    head_dest;
    logic [AW-1:0] occ_off;
    logic [31:0]   busy_gpr_c;
    logic [31:0]   busy_fpr_c;

    assign not_empty = (cnt != '0);
    assign full      = (cnt == CW'(DEPTH));
    assign rdy       = !full && !wb.flush;
    assign push      = wb.res_valid && rdy;
    // Dest-0 GPR entries still pop: they are retired without a write.
    assign pop       = not_empty && !wb.wb_stall && !wb.flush;

    assign head_flt  = flt_q[rd_ptr];
    assign head_dest = dest_q[rd_ptr];

    assign wb.res_ready   = rdy;
    assign wb.count       = cnt;
    assign wb.write_data  = data_q[rd_ptr];
    assign wb.rd          = head_dest;
    assign wb.frd         = head_dest;
    assign wb.float_write = pop && head_flt;
    assign wb.reg_write   = pop && !head_flt && (head_dest != 5'd0);

    // Pointer and occupancy bookkeeping; flush beats any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (wb.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are only meaningful inside the occupied window, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= wb.res_data;
            dest_q[wr_ptr] <= wb.res_dest;
            flt_q[wr_ptr]  <= wb.res_is_float;
        end
    end

    // Scoreboard masks: scan every slot and keep those inside the [rd_ptr, rd_ptr+cnt) window.
    always_comb begin
        busy_gpr_c = '0;
        busy_fpr_c = '0;
        occ_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_off = AW'(i) - rd_ptr;
            if ({1'b0, occ_off} < cnt) begin
                if (flt_q[i]) busy_fpr_c[dest_q[i]] = 1'b1;
                else          busy_gpr_c[dest_q[i]] = 1'b1;
            end
        end
        // x0 is hardwired, so it is never a pending destination.
        busy_gpr_c[0] = 1'b0;
    end

    assign wb.busy_gpr = busy_gpr_c;
    assign wb.busy_fpr = busy_fpr_c;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then random traffic against a queue model.
// Latency: checks every cycle at the falling edge, model advances at the rising edge.
// Backpressure: producer holds a result until the model-predicted accept cycle.
module tb_writeback_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  r;
        logic        f;
    } ent_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    bit   acc;
    ent_t q[$];

    writeback_if #(.DEPTH(DEPTH)) wbi ();

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wbi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every observable output with what the queue model says it should be.
    task automatic check_model();
        logic [31:0] eg;
        logic [31:0] ef;
        logic        erw;
        logic        efw;
        logic        erdy;
        eg = '0;
        ef = '0;
        foreach (q[k]) begin
            if (q[k].f) ef[q[k].r] = 1'b1;
            else if (q[k].r != 5'd0) eg[q[k].r] = 1'b1;
        end
        erdy = (q.size() != DEPTH) && !wbi.flush;
        efw  = (q.size() != 0) && q[0].f && !wbi.wb_stall && !wbi.flush;
        erw  = (q.size() != 0) && !q[0].f && (q[0].r != 5'd0) && !wbi.wb_stall && !wbi.flush;
        chk("count",       32'(wbi.count), 32'(q.size()));
        chk("res_ready",   32'(wbi.res_ready), 32'(erdy));
        chk("reg_write",   32'(wbi.reg_write), 32'(erw));
        chk("float_write", 32'(wbi.float_write), 32'(efw));
        chk("busy_gpr",    wbi.busy_gpr, eg);
        chk("busy_fpr",    wbi.busy_fpr, ef);
        if (erw) begin
            chk("rd",         32'(wbi.rd), 32'(q[0].r));
            chk("write_data", wbi.write_data, q[0].d);
        end
        if (efw) begin
            chk("frd",        32'(wbi.frd), 32'(q[0].r));
            chk("write_data", wbi.write_data, q[0].d);
        end
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        @(negedge clk);
        check_model();
        acc = wbi.res_valid && (q.size() != DEPTH) && !wbi.flush;
        if (wbi.flush) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && !wbi.wb_stall;
            do_push = wbi.res_valid && (q.size() != DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.d = wbi.res_data;
                e.r = wbi.res_dest;
                e.f = wbi.res_is_float;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one result and hold it until accepted (bounded wait).
    task automatic push_one(input logic [31:0] d, input logic [4:0] r, input logic f);
        int n;
        wbi.res_valid    = 1'b1;
        wbi.res_data     = d;
        wbi.res_dest     = r;
        wbi.res_is_float = f;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            cycle();
            n++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        wbi.res_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        wbi.res_valid    = 1'b0;
        wbi.res_data     = '0;
        wbi.res_dest     = '0;
        wbi.res_is_float = 1'b0;
        wbi.wb_stall     = 1'b0;
        wbi.flush        = 1'b0;

        // Reset state
        #3;
        chk("rst_count", 32'(wbi.count), 32'd0);
        chk("rst_rw",    32'(wbi.reg_write), 32'd0);
        chk("rst_fw",    32'(wbi.float_write), 32'd0);
        chk("rst_busyg", wbi.busy_gpr, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(wbi.res_ready), 32'd1);

        // Single integer result, dest 5
        push_one(32'h0000_0007, 5'd5, 1'b0);
        @(negedge clk);
        chk("single_rw",    32'(wbi.reg_write), 32'd1);
        chk("single_rd",    32'(wbi.rd), 32'd5);
        chk("single_data",  wbi.write_data, 32'd7);
        chk("single_busy",  wbi.busy_gpr, 32'h0000_0020);
        @(posedge clk);
        #1;
        void'(q.pop_front());
        cycle();
        chk("single_after_busy",  wbi.busy_gpr, 32'd0);
        chk("single_after_count", 32'(wbi.count), 32'd0);

        // Fill with stall high, fifth result held, then drain in order
        wbi.wb_stall = 1'b1;
        push_one(32'h1111_0001, 5'd1, 1'b0);
        push_one(32'h3F80_0000, 5'd3, 1'b1);
        push_one(32'h1111_0003, 5'd7, 1'b0);
        push_one(32'h1111_0004, 5'd9, 1'b1);
        wbi.res_valid    = 1'b1;
        wbi.res_data     = 32'h1111_0005;
        wbi.res_dest     = 5'd11;
        wbi.res_is_float = 1'b0;
        cycle();
        chk("full_count", 32'(wbi.count), 32'd4);
        chk("full_ready", 32'(wbi.res_ready), 32'd0);
        wbi.wb_stall = 1'b0;
        push_one(32'h1111_0005, 5'd11, 1'b0);
        idle(6);

        // Dest-zero integer result is dropped without a write
        push_one(32'hDEAD_0000, 5'd0, 1'b0);
        idle(2);

        // Simultaneous enqueue and dequeue across pointer wrap
        wbi.wb_stall = 1'b1;
        push_one(32'h2222_0000, 5'd12, 1'b0);
        push_one(32'h2222_0001, 5'd13, 1'b1);
        wbi.wb_stall = 1'b0;
        for (int i = 2; i < DEPTH + 2; i++) begin
            push_one(32'h2222_0000 + 32'(i), 5'(14 + i), 1'(i & 1));
            chk("simul_count", 32'(q.size()), 32'd2);
        end
        idle(4);

        // Flush with three entries queued and a result offered the same cycle
        wbi.wb_stall = 1'b1;
        push_one(32'h3333_0001, 5'd1, 1'b0);
        push_one(32'h3333_0002, 5'd2, 1'b1);
        push_one(32'h3333_0003, 5'd3, 1'b0);
        wbi.wb_stall  = 1'b0;
        wbi.flush     = 1'b1;
        wbi.res_valid = 1'b1;
        cycle();
        wbi.flush     = 1'b0;
        wbi.res_valid = 1'b0;
        cycle();
        chk("flush_count", 32'(wbi.count), 32'd0);
        chk("flush_busyg", wbi.busy_gpr, 32'd0);
        chk("flush_busyf", wbi.busy_fpr, 32'd0);

        // Asynchronous reset mid-cycle with the queue full and draining
        wbi.wb_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_one(32'h4444_0000 + 32'(i), 5'(20 + i), 1'(i & 1));
        wbi.wb_stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_count", 32'(wbi.count), 32'd0);
        chk("arst_rw",    32'(wbi.reg_write), 32'd0);
        chk("arst_fw",    32'(wbi.float_write), 32'd0);
        chk("arst_busyg", wbi.busy_gpr, 32'd0);
        chk("arst_busyf", wbi.busy_fpr, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            wbi.res_valid    = ($urandom_range(0, 9) < 7);
            wbi.res_data     = $urandom;
            wbi.res_dest     = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wbi.res_is_float = 1'($urandom_range(0, 1));
            wbi.wb_stall     = ($urandom_range(0, 9) < 3);
            wbi.flush        = ($urandom_range(0, 49) == 0);
            chk("excl", 32'(wbi.reg_write & wbi.float_write), 32'd0);
            cycle();
        end
        wbi.res_valid = 1'b0;
        wbi.wb_stall  = 1'b0;
        wbi.flush     = 1'b0;
        idle(DEPTH + 2);
        chk("final_count", 32'(wbi.count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
